nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_adder_pkg.sv | 24 ++
 rtl/nibble_serial_adder_cla.sv | 46 ++++
 rtl/nibble_serial_adder.sv | 203 ++++++++++++++++++++
 tb/tb_nibble_serial_adder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// nibble_serial_pkg
// Shared definitions for the nibble-serial adder:
//   state_t   - controller states (IDLE, RUN, DONE)
//   NIBBLE_W  - width of one CLA slice (4 bits)
//   idx_width - width of the nibble counter, clog2(nibbles) with a floor of 1
// ---------------------------------------------------------------------------
package nibble_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

    // A single-nibble adder still needs a 1-bit counter to keep the
    // declarations legal, hence the floor of 1.
    function automatic int idx_width(input int nibbles);
        return ($clog2(nibbles) < 1) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_cla.sv
// ---------------------------------------------------------------------------
// CLA_4bit
// 4-bit carry-lookahead adder slice.
// Ports:
//   A, B  (in,  4) operand nibbles
//   Cin   (in,  1) carry in
//   S     (out, 4) sum nibble
//   Cout  (out, 1) carry out
//   PG    (out, 1) group propagate (every bit propagates)
//   GG    (out, 1) group generate
// ---------------------------------------------------------------------------
module CLA_4bit
    import nibble_serial_pkg::*;
(
    output logic [NIBBLE_W-1:0] S,
    output logic                Cout,
    output logic                PG,
    output logic                GG,
    input  logic [NIBBLE_W-1:0] A,
    input  logic [NIBBLE_W-1:0] B,
    input  logic                Cin
);

    logic [NIBBLE_W-1:0] w_p;
    logic [NIBBLE_W-1:0] w_g;
    logic [NIBBLE_W:0]   w_c;

    assign w_p = A ^ B;
    assign w_g = A & B;

    // Each carry expanded from the generate/propagate terms, no ripple.
    assign w_c[0] = Cin;
    assign w_c[1] = w_g[0] | (w_p[0] & Cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & Cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & Cin);
    assign w_c[4] = GG | (PG & Cin);

    assign PG = &w_p;
    assign GG = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

    assign S    = w_p ^ w_c[NIBBLE_W-1:0];
    assign Cout = w_c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder
// WIDTH-bit adder that reuses one CLA_4bit slice, one nibble per cycle,
// with the slice carry registered between nibbles.
// Optional feature macro: NIBBLE_SERIAL_FLAGS_EN (adds zero/ovf/all_prop).
// Ports:
//   clk        (in)         system clock, rising edge
//   rst_n      (in)         synchronous active-low reset
//   in_valid   (in)         a/b/cin valid
//   in_ready   (out)        accepting operands (IDLE only)
//   a, b       (in, WIDTH)  operands
//   cin        (in)         carry into bit 0
//   out_valid  (out)        sum/cout valid (DONE)
//   out_ready  (in)         consumer takes the result
//   sum        (out, WIDTH) registered result
//   cout       (out)        carry out of bit WIDTH-1
//   zero       (out)        [flags] final sum is zero
//   ovf        (out)        [flags] signed overflow
//   all_prop   (out)        [flags] every nibble's group propagate was set
// ---------------------------------------------------------------------------
module nibble_serial_adder
    import nibble_serial_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef NIBBLE_SERIAL_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf,
    output logic             all_prop
`endif
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic [NIBBLE_W-1:0] w_nib_a;
    logic [NIBBLE_W-1:0] w_nib_b;
    logic [NIBBLE_W-1:0] w_s;
    logic                w_cout;
    logic                w_pg;
    logic                w_gg;
    logic                w_last;
    logic [WIDTH-1:0]    w_sum_next;

    // ---- slice operand select and the shared CLA slice ----
    assign w_nib_a = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
    assign w_nib_b = r_b[r_idx*NIBBLE_W +: NIBBLE_W];
    assign w_last  = (r_idx == LAST_IDX);

    CLA_4bit u_cla (
        .S    (w_s),
        .Cout (w_cout),
        .PG   (w_pg),
        .GG   (w_gg),
        .A    (w_nib_a),
        .B    (w_nib_b),
        .Cin  (r_carry)
    );

    // Current sum with this cycle's nibble merged in; on the last RUN cycle
    // this is the final result, which the flags are computed from.
    always_comb begin
        w_sum_next = r_sum;
        w_sum_next[r_idx*NIBBLE_W +: NIBBLE_W] = w_s;
    end

    // ---- controller ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ---- datapath ----
`ifdef NIBBLE_SERIAL_FLAGS_EN
    logic r_prop_acc;
    logic r_zero;
    logic r_ovf;
    logic r_all_prop;
    logic w_unused_gg;

    assign w_unused_gg = w_gg;
`else
    logic w_unused_pg_gg;

    assign w_unused_pg_gg = w_pg ^ w_gg;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
`ifdef NIBBLE_SERIAL_FLAGS_EN
            r_prop_acc <= 1'b0;
            r_zero     <= 1'b0;
            r_ovf      <= 1'b0;
            r_all_prop <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
`ifdef NIBBLE_SERIAL_FLAGS_EN
                        r_prop_acc <= 1'b1;
`endif
                    end
                end
                RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_cout;
`ifdef NIBBLE_SERIAL_FLAGS_EN
                    r_prop_acc <= r_prop_acc & w_pg;
`endif
                    if (w_last) begin
                        r_cout <= w_cout;
`ifdef NIBBLE_SERIAL_FLAGS_EN
                        r_zero     <= (w_sum_next == '0);
                        // carry into the MSB recovered from the MSB sum bit
                        r_ovf      <= r_a[WIDTH-1] ^ r_b[WIDTH-1]
                                    ^ w_sum_next[WIDTH-1] ^ w_cout;
                        r_all_prop <= r_prop_acc & w_pg;
`endif
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
`ifdef NIBBLE_SERIAL_FLAGS_EN
    assign zero     = r_zero;
    assign ovf      = r_ovf;
    assign all_prop = r_all_prop;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

    localparam int W       = 16;
    localparam int NIBBLES = W / 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef NIBBLE_SERIAL_FLAGS_EN
    logic         zero;
    logic         ovf;
    logic         all_prop;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef NIBBLE_SERIAL_FLAGS_EN
        ,
        .zero      (zero),
        .ovf       (ovf),
        .all_prop  (all_prop)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction: accept, wait for result, check it against plain
    // integer arithmetic, hold it under backpressure, then hand it off.
    task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input logic ci, input int hold, input bit isolate);
        logic [W:0] exp;
        int         n;
        int         sr;
        exp = {1'b0, ai} + {1'b0, bi} + {{W{1'b0}}, ci};
        sr  = int'($signed(ai)) + int'($signed(bi)) + int'(ci);

        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("accept_ready", {31'd0, in_ready}, 32'd1);

        a = ai; b = bi; cin = ci; in_valid = 1'b1;
        tick();
        if (isolate) begin
            a   = 16'hFFFF;
            b   = 16'($urandom);
            cin = 1'b1;
        end else begin
            in_valid = 1'b0;
        end

        n = 0;
        while (!out_valid && n < 50) begin
            chk("run_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
            n++;
        end
        chk("latency", n, NIBBLES);
        chk("sum", {16'd0, sum}, {16'd0, exp[W-1:0]});
        chk("cout", {31'd0, cout}, {31'd0, exp[W]});
`ifdef NIBBLE_SERIAL_FLAGS_EN
        chk("zero", {31'd0, zero}, {31'd0, (exp[W-1:0] == '0)});
        chk("ovf", {31'd0, ovf}, {31'd0, (sr > 32767 || sr < -32768)});
        chk("all_prop", {31'd0, all_prop}, {31'd0, ((ai ^ bi) == 16'hFFFF)});
`endif

        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_sum", {16'd0, sum}, {16'd0, exp[W-1:0]});
            chk("hold_cout", {31'd0, cout}, {31'd0, exp[W]});
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end

        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("release_valid", {31'd0, out_valid}, 32'd0);
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
`ifdef NIBBLE_SERIAL_FLAGS_EN
        chk("rst_zero", {31'd0, zero}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_all_prop", {31'd0, all_prop}, 32'd0);
`endif
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // directed cases
        run_op(16'h00FF, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'h0000, 1'b1, 0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'h1111, 16'h4444, 1'b0, 6, 1'b0);
        run_op(16'h0F0F, 16'hF0F1, 1'b1, 1, 1'b0);
        run_op(16'h1234, 16'h4321, 1'b0, 2, 1'b1);
        run_op(16'h8000, 16'h8000, 1'b0, 0, 1'b0);

        // reset on the second RUN cycle discards the operation
        while (!in_ready) tick();
        a = 16'hABCD; b = 16'h1357; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_sum", {16'd0, sum}, 32'd0);
        chk("midrst_cout", {31'd0, cout}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("midrst_no_valid", {31'd0, out_valid}, 32'd0);
        run_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0);

        // randomized operations
        for (int k = 0; k < 30; k++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
